// File: rtl/ft_lockstep_if.sv
// Lockstep core-pair bus: per-port register writes from both cores,
// retired PC, and the recovery control/replay outputs.
interface ft_lockstep_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_PORTS  = 2
);
   logic [NUM_PORTS-1:0]            we_a_i;
   logic [NUM_PORTS-1:0]            we_b_i;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_a_i;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_b_i;
   logic [NUM_PORTS*DATA_WIDTH-1:0] data_a_i;
   logic [NUM_PORTS*DATA_WIDTH-1:0] data_b_i;
   logic                            spc_valid_i;
   logic [DATA_WIDTH-1:0]           spc_i;
   logic [DATA_WIDTH-1:0]           spc_o;
   logic [ADDR_WIDTH-1:0]           addr_o;
   logic [DATA_WIDTH-1:0]           data_o;
   logic                            replay_valid_o;
   logic                            halt_o;
   logic                            reset_o;
   logic                            resume_o;
   logic                            fatal_o;
   logic [7:0]                      error_count_o;

   // Design side
   modport slave (
      input  we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i,
             spc_valid_i, spc_i,
      output spc_o, addr_o, data_o, replay_valid_o, halt_o, reset_o,
             resume_o, fatal_o, error_count_o
   );

   // Core-pair / environment side
   modport master (
      output we_a_i, we_b_i, addr_a_i, addr_b_i, data_a_i, data_b_i,
             spc_valid_i, spc_i,
      input  spc_o, addr_o, data_o, replay_valid_o, halt_o, reset_o,
             resume_o, fatal_o, error_count_o
   );
endinterface

// File: rtl/ft_lockstep_unit.sv
// Dual-core lockstep checker: compares register writes of two cores,
// keeps a shadow register file and last committed PC, and on divergence
// runs halt -> reset -> replay -> resume, escalating to FATAL after
// MAX_RETRIES consecutive recoveries without a good commit.
module ft_lockstep_unit #(
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_PORTS    = 2,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned RESET_CYCLES = 2
) (
   input  logic           clk_i,
   input  logic           rst_n,
   ft_lockstep_if.slave   bus
);

   localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
   localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam int unsigned RCNT_W  = 4;

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_HALT   = 3'd1,
      S_RESET  = 3'd2,
      S_REPLAY = 3'd3,
      S_RESUME = 3'd4,
      S_FATAL  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shadow [DEPTH];
   logic [DATA_WIDTH-1:0] r_spc;
   logic [RETRY_W-1:0]    r_retry;
   logic [7:0]            r_err_cnt;
   logic [RCNT_W-1:0]     r_rst_cnt;
   logic [ADDR_WIDTH-1:0] r_replay_cnt;
   logic                  r_halt;
   logic                  r_reset;
   logic                  r_replay;
   logic                  r_resume;
   logic                  r_fatal;

   logic [NUM_PORTS-1:0]  w_port_mis;
   logic                  w_any_we;
   logic                  w_error;
   logic                  w_commit;
   logic                  w_retry_hit;
   logic                  w_halt_nxt;
   logic                  w_reset_nxt;
   logic                  w_replay_nxt;
   logic                  w_resume_nxt;
   logic                  w_fatal_nxt;

   // Per-port divergence between the two cores and whether any write is present
   always_comb begin
      w_port_mis = '0;
      w_any_we   = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_port_mis[p] = (bus.we_a_i[p] != bus.we_b_i[p]) ||
                         (bus.we_a_i[p] && bus.we_b_i[p] &&
                          ((bus.addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH] !=
                            bus.addr_b_i[p*ADDR_WIDTH +: ADDR_WIDTH]) ||
                           (bus.data_a_i[p*DATA_WIDTH +: DATA_WIDTH] !=
                            bus.data_b_i[p*DATA_WIDTH +: DATA_WIDTH])));
         w_any_we      = w_any_we | (bus.we_a_i[p] & bus.we_b_i[p]);
      end
   end

   assign w_error     = (r_state == S_RUN) && (|w_port_mis);
   assign w_commit    = (r_state == S_RUN) && !(|w_port_mis);
   assign w_retry_hit = (r_retry == RETRY_W'(MAX_RETRIES));

   // Next-state decode and next values of the registered strobes
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_RUN: begin
            if (w_error) begin
               w_state_nxt = w_retry_hit ? S_FATAL : S_HALT;
            end
         end
         S_HALT:   w_state_nxt = S_RESET;
         S_RESET: begin
            if (r_rst_cnt == RCNT_W'(RESET_CYCLES - 1)) begin
               w_state_nxt = S_REPLAY;
            end
         end
         S_REPLAY: begin
            if (r_replay_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
               w_state_nxt = S_RESUME;
            end
         end
         S_RESUME: w_state_nxt = S_RUN;
         S_FATAL:  w_state_nxt = S_FATAL;
         default:  w_state_nxt = S_RUN;
      endcase
      w_halt_nxt   = (w_state_nxt == S_HALT) || (w_state_nxt == S_FATAL);
      w_reset_nxt  = (w_state_nxt == S_RESET);
      w_replay_nxt = (w_state_nxt == S_REPLAY);
      w_resume_nxt = (w_state_nxt == S_RESUME);
      w_fatal_nxt  = (w_state_nxt == S_FATAL);
   end

   // State register and registered control strobes
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_RUN;
         r_halt   <= 1'b0;
         r_reset  <= 1'b0;
         r_replay <= 1'b0;
         r_resume <= 1'b0;
         r_fatal  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halt   <= w_halt_nxt;
         r_reset  <= w_reset_nxt;
         r_replay <= w_replay_nxt;
         r_resume <= w_resume_nxt;
         r_fatal  <= w_fatal_nxt;
      end
   end

   // Recovery sequencing counters; the replay counter wraps to 0 after the last beat
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_cnt    <= '0;
         r_replay_cnt <= '0;
      end else begin
         r_rst_cnt    <= (r_state == S_RESET) ? r_rst_cnt + RCNT_W'(1) : '0;
         if (r_state == S_REPLAY) begin
            r_replay_cnt <= r_replay_cnt + ADDR_WIDTH'(1);
         end
      end
   end

   // Error statistics and consecutive-retry tracking
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
         r_retry   <= '0;
      end else begin
         if (w_error && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (w_error && !w_retry_hit) begin
            r_retry <= r_retry + RETRY_W'(1);
         end else if (w_commit && w_any_we) begin
            r_retry <= '0;
         end
      end
   end

   // Last committed PC
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_spc <= '0;
      end else if (w_commit && bus.spc_valid_i) begin
         r_spc <= bus.spc_i;
      end
   end

   // Shadow register file; later ports overwrite earlier ones on equal addresses
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_shadow[i] <= '0;
         end
      end else if (w_commit) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (bus.we_a_i[p] && bus.we_b_i[p]) begin
               r_shadow[bus.addr_a_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <=
                  bus.data_a_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign bus.halt_o         = r_halt;
   assign bus.reset_o        = r_reset;
   assign bus.replay_valid_o = r_replay;
   assign bus.resume_o       = r_resume;
   assign bus.fatal_o        = r_fatal;
   assign bus.addr_o         = r_replay_cnt;
   assign bus.data_o         = r_shadow[r_replay_cnt];
   assign bus.spc_o          = r_spc;
   assign bus.error_count_o  = r_err_cnt;

endmodule

// File: tb/tb_ft_lockstep_unit.sv
// Self-checking bench for ft_lockstep_unit: directed scenarios plus
// randomized traffic against a cycle-indexed behavioural model.
module tb_ft_lockstep_unit;

   localparam int AW      = 5;
   localparam int DW      = 32;
   localparam int NP      = 2;
   localparam int MR      = 3;
   localparam int RC      = 2;
   localparam int DEPTH   = 32;
   localparam int SEQ_LEN = RC + DEPTH + 2;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;

   ft_lockstep_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

   ft_lockstep_unit #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP),
      .MAX_RETRIES(MR), .RESET_CYCLES(RC)
   ) dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_mis = 0;

   // Stimulus for the next edge
   logic [NP-1:0]    s_we_a, s_we_b;
   logic [NP*AW-1:0] s_addr_a, s_addr_b;
   logic [NP*DW-1:0] s_data_a, s_data_b;
   logic             s_spc_valid;
   logic [DW-1:0]    s_spc;

   // Model: m_phase = -1 while running, else cycles elapsed in recovery
   int            m_phase;
   bit            m_fatal;
   logic [DW-1:0] m_shadow [DEPTH];
   logic [DW-1:0] m_spc;
   int            m_retry;
   int            m_errs;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = -1;
      m_fatal = 1'b0;
      m_spc   = '0;
      m_retry = 0;
      m_errs  = 0;
      for (int i = 0; i < DEPTH; i++) m_shadow[i] = '0;
   endtask

   task automatic model_step();
      bit err;
      bit wrote;
      if (m_fatal) return;
      if (m_phase >= 0) begin
         m_phase++;
         if (m_phase == SEQ_LEN) m_phase = -1;
         return;
      end
      err = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (s_we_a[p] != s_we_b[p]) err = 1'b1;
         else if (s_we_a[p] && ((s_addr_a[p*AW +: AW] != s_addr_b[p*AW +: AW]) ||
                                (s_data_a[p*DW +: DW] != s_data_b[p*DW +: DW]))) err = 1'b1;
      end
      if (err) begin
         if (m_errs < 255) m_errs++;
         if (m_retry == MR) m_fatal = 1'b1;
         else begin
            m_retry++;
            m_phase = 0;
         end
      end else begin
         wrote = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (s_we_a[p] && s_we_b[p]) begin
               m_shadow[int'(s_addr_a[p*AW +: AW])] = s_data_a[p*DW +: DW];
               wrote = 1'b1;
            end
         end
         if (wrote) m_retry = 0;
         if (s_spc_valid) m_spc = s_spc;
      end
   endtask

   task automatic check_outputs();
      bit e_halt, e_reset, e_replay, e_resume;
      int e_addr;
      e_halt   = m_fatal || (m_phase == 0);
      e_reset  = (m_phase >= 1) && (m_phase <= RC);
      e_replay = (m_phase >= RC + 1) && (m_phase <= RC + DEPTH);
      e_resume = (m_phase == RC + DEPTH + 1);
      e_addr   = e_replay ? (m_phase - RC - 1) : 0;
      check_val("strobes{halt,reset,replay,resume,fatal}",
                64'({bus.halt_o, bus.reset_o, bus.replay_valid_o, bus.resume_o, bus.fatal_o}),
                64'({e_halt, e_reset, e_replay, e_resume, m_fatal}));
      check_val("addr_o", 64'(bus.addr_o), 64'(e_addr));
      check_val("data_o", 64'(bus.data_o), 64'(m_shadow[e_addr]));
      check_val("spc_o", 64'(bus.spc_o), 64'(m_spc));
      check_val("error_count_o", 64'(bus.error_count_o), 64'(m_errs));
   endtask

   task automatic set_idle();
      s_we_a = '0; s_we_b = '0;
      s_addr_a = '0; s_addr_b = '0;
      s_data_a = '0; s_data_b = '0;
      s_spc_valid = 1'b0; s_spc = '0;
   endtask

   task automatic set_match(input int p, input int addr, input logic [DW-1:0] data);
      s_we_a[p] = 1'b1;
      s_we_b[p] = 1'b1;
      s_addr_a[p*AW +: AW] = AW'(addr);
      s_addr_b[p*AW +: AW] = AW'(addr);
      s_data_a[p*DW +: DW] = data;
      s_data_b[p*DW +: DW] = data;
   endtask

   // Drive at a falling edge, advance the model, check at the next falling edge
   task automatic step();
      bus.we_a_i      = s_we_a;
      bus.we_b_i      = s_we_b;
      bus.addr_a_i    = s_addr_a;
      bus.addr_b_i    = s_addr_b;
      bus.data_a_i    = s_data_a;
      bus.data_b_i    = s_data_b;
      bus.spc_valid_i = s_spc_valid;
      bus.spc_i       = s_spc;
      model_step();
      @(negedge clk_i);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk_i);
      check_outputs();
      rst_n = 1'b1;
   endtask

   // Walk one recovery from the halt cycle, counting strobes and sampling two replay beats
   task automatic recover(input int wa0, input logic [DW-1:0] wv0,
                          input int wa1, input logic [DW-1:0] wv1);
      int n_halt, n_reset, n_replay, n_resume, n_inorder;
      logic [DW-1:0] g0, g1;
      n_halt = 0; n_reset = 0; n_replay = 0; n_resume = 0; n_inorder = 0;
      g0 = 'x; g1 = 'x;
      set_idle();
      for (int k = 0; k < SEQ_LEN + 4; k++) begin
         if (bus.halt_o) n_halt++;
         if (bus.reset_o) n_reset++;
         if (bus.resume_o) n_resume++;
         if (bus.replay_valid_o) begin
            if (int'(bus.addr_o) == n_replay) n_inorder++;
            n_replay++;
            if (int'(bus.addr_o) == wa0) g0 = bus.data_o;
            if (int'(bus.addr_o) == wa1) g1 = bus.data_o;
         end
         step();
      end
      check_val("rec_halt_cycles", 64'(n_halt), 64'd1);
      check_val("rec_reset_cycles", 64'(n_reset), 64'd2);
      check_val("rec_replay_beats", 64'(n_replay), 64'd32);
      check_val("rec_replay_in_order", 64'(n_inorder), 64'd32);
      check_val("rec_resume_cycles", 64'(n_resume), 64'd1);
      check_val("rec_watch0", 64'(g0), 64'(wv0));
      check_val("rec_watch1", 64'(g1), 64'(wv1));
   endtask

   initial begin
      bit reached;
      int pp;
      set_idle();
      model_reset();
      bus.we_a_i = '0; bus.we_b_i = '0; bus.addr_a_i = '0; bus.addr_b_i = '0;
      bus.data_a_i = '0; bus.data_b_i = '0; bus.spc_valid_i = 1'b0; bus.spc_i = '0;
      repeat (3) @(negedge clk_i);
      check_outputs();
      rst_n = 1'b1;

      // Matched writes on both ports plus a retired PC, committed on the first edge
      set_idle();
      set_match(0, 3, 32'hDEADBEEF);
      set_match(1, 5, 32'h12345678);
      s_spc_valid = 1'b1; s_spc = 32'h100;
      step();
      check_val("commit_spc", 64'(bus.spc_o), 64'h100);
      check_val("commit_no_strobes",
                64'({bus.halt_o, bus.reset_o, bus.replay_valid_o, bus.resume_o, bus.fatal_o}), 64'd0);
      set_idle();
      step();

      // Single-bit data divergence: write must be dropped
      set_idle();
      set_match(0, 9, 32'h55);
      s_data_b[0 +: DW] = 32'h45;
      s_spc_valid = 1'b1; s_spc = 32'h200;
      step();
      recover(3, 32'hDEADBEEF, 9, 32'h0);
      check_val("err_count_1", 64'(bus.error_count_o), 64'd1);
      check_val("spc_kept", 64'(bus.spc_o), 64'h100);

      // Enable divergence on port 1 only
      set_idle();
      s_we_a[1] = 1'b1;
      step();
      recover(5, 32'h12345678, 3, 32'hDEADBEEF);
      check_val("err_count_2", 64'(bus.error_count_o), 64'd2);

      // Same-address writes on both ports: higher port wins
      set_idle();
      set_match(0, 7, 32'hA);
      set_match(1, 7, 32'hB);
      step();
      set_idle();
      s_we_b[0] = 1'b1;
      step();
      recover(7, 32'hB, 3, 32'hDEADBEEF);

      // Good commit between every error keeps retries from accumulating
      for (int i = 0; i < 4; i++) begin
         set_idle();
         set_match(0, 10 + i, DW'(i + 1));
         step();
         set_idle();
         s_we_a[0] = 1'b1;
         step();
         recover(10 + i, DW'(i + 1), 3, 32'hDEADBEEF);
      end
      check_val("no_fatal_with_commits", 64'(bus.fatal_o), 64'd0);

      // Persistent divergence with no commit: fourth error is fatal
      set_idle();
      set_match(0, 20, 32'hC0FFEE);
      step();
      set_idle();
      s_we_a[1] = 1'b1;
      for (int k = 0; k < 4 * SEQ_LEN + 10; k++) step();
      check_val("fatal_o_held", 64'(bus.fatal_o), 64'd1);
      check_val("fatal_halt_held", 64'(bus.halt_o), 64'd1);
      check_val("err_count_11", 64'(bus.error_count_o), 64'd11);
      set_idle();
      set_match(0, 1, 32'hFFFF);
      for (int k = 0; k < 5; k++) step();
      check_val("fatal_ignores_inputs", 64'(bus.fatal_o), 64'd1);
      do_reset();
      check_val("fatal_cleared", 64'(bus.fatal_o), 64'd0);

      // Asynchronous reset at replay beat 10
      set_idle();
      set_match(0, 3, 32'h77);
      step();
      set_idle();
      s_we_a[0] = 1'b1;
      step();
      set_idle();
      reached = 1'b0;
      for (int k = 0; k < 60 && !reached; k++) begin
         if (bus.replay_valid_o && bus.addr_o == 5'd10) reached = 1'b1;
         else step();
      end
      check_val("reached_beat10", 64'(reached), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_strobes",
                64'({bus.halt_o, bus.reset_o, bus.replay_valid_o, bus.resume_o, bus.fatal_o}), 64'd0);
      check_val("async_rst_addr", 64'(bus.addr_o), 64'd0);
      check_val("async_rst_data", 64'(bus.data_o), 64'd0);
      check_val("async_rst_spc", 64'(bus.spc_o), 64'd0);
      check_val("async_rst_errs", 64'(bus.error_count_o), 64'd0);
      model_reset();
      @(negedge clk_i);
      rst_n = 1'b1;
      set_idle();
      s_we_b[1] = 1'b1;
      step();
      recover(3, 32'h0, 10, 32'h0);

      // Randomized traffic
      for (int k = 0; k < 2500; k++) begin
         set_idle();
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) == 1)
               set_match(p, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)),
                         DW'($urandom));
         end
         s_spc_valid = ($urandom_range(0, 1) == 1);
         s_spc = DW'($urandom);
         if ($urandom_range(0, 24) == 0) begin
            pp = int'($urandom_range(0, NP - 1));
            case ($urandom_range(0, 2))
               0: s_we_b[pp] = ~s_we_b[pp];
               1: s_addr_b[pp*AW + int'($urandom_range(0, AW - 1))] ^= 1'b1;
               default: s_data_b[pp*DW + int'($urandom_range(0, DW - 1))] ^= 1'b1;
            endcase
         end
         step();
         if (m_fatal && $urandom_range(0, 7) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
